// File: rtl/oled_spi_sequencer.sv
// oled_spi_sequencer: Pmod OLED power-up/reset, fixed SSD1306 init list, then user bytes over SPI, all paced by ticks from the divided clock sclk_src (ports: clk_in/reset, sclk_src, byte_* handshake, init_done, oled_* pins)
module oled_spi_sequencer #(
  parameter int VDD_TICKS  = 1,
  parameter int RES_TICKS  = 1,
  parameter int VBAT_TICKS = 10,
  parameter int CNT_W      = 8
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       sclk_src,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_is_data,
  output logic       byte_ready,
  output logic       init_done,
  output logic       oled_cs_n,
  output logic       oled_sclk,
  output logic       oled_sdin,
  output logic       oled_dc,
  output logic       oled_res_n,
  output logic       oled_vdd_n,
  output logic       oled_vbat_n
);
  typedef enum logic [2:0] {WAIT_VDD, RES_LOW, RES_SETTLE, INIT_A, WAIT_VBAT, INIT_B, IDLE, USER_TX} state_t;
  state_t state, state_nxt;
  logic s1, s2, s3, tick, busy, load, ld_dc, wait_done, byte_done;
  logic [CNT_W-1:0] cnt, lim;
  logic [3:0] idx;
  logic [4:0] bcnt;
  logic [7:0] shreg, ld_byte, rom_byte;
  assign tick = s2 ^ s3;
  assign lim = state == WAIT_VDD ? CNT_W'(VDD_TICKS - 1) : state == WAIT_VBAT ? CNT_W'(VBAT_TICKS - 1) : CNT_W'(RES_TICKS - 1);
  assign wait_done = tick && cnt == lim;
  assign byte_done = busy && tick && bcnt == 5'd16;
  always_comb begin
    rom_byte = 8'h00;
    case (idx)
      4'd0:  rom_byte = 8'hAE;
      4'd1:  rom_byte = 8'h8D;
      4'd2:  rom_byte = 8'h14;
      4'd3:  rom_byte = 8'hD9;
      4'd4:  rom_byte = 8'hF1;
      4'd5:  rom_byte = 8'hA1;
      4'd6:  rom_byte = 8'hC8;
      4'd7:  rom_byte = 8'hDA;
      4'd8:  rom_byte = 8'h20;
      4'd9:  rom_byte = 8'hAF;
      4'd10: rom_byte = 8'hA4;
      default: rom_byte = 8'h00;
    endcase
  end
  always_ff @(posedge clk_in or posedge reset)
    if (reset) state <= WAIT_VDD;
    else state <= state_nxt;
  // Init loads wait for a tick-free cycle so the first tick of every byte lands strictly after its load.
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    ld_byte = rom_byte;
    ld_dc = 1'b0;
    case (state)
      WAIT_VDD:   state_nxt = wait_done ? RES_LOW : state;
      RES_LOW:    state_nxt = wait_done ? RES_SETTLE : state;
      RES_SETTLE: state_nxt = wait_done ? INIT_A : state;
      WAIT_VBAT:  state_nxt = wait_done ? INIT_B : state;
      INIT_A, INIT_B: begin
        if (!busy && idx == (state == INIT_A ? 4'd5 : 4'd11)) state_nxt = state == INIT_A ? WAIT_VBAT : IDLE;
        else load = !busy && !tick;
      end
      IDLE: if (byte_valid && byte_ready) begin
        state_nxt = USER_TX;
        load = 1'b1;
        ld_byte = byte_data;
        ld_dc = byte_is_data;
      end
      USER_TX: state_nxt = byte_done ? IDLE : state;
      default: state_nxt = WAIT_VDD;
    endcase
  end
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      {s1, s2, s3} <= 3'b000;
      cnt <= '0;
      idx <= 4'd0;
      shreg <= 8'h00;
      bcnt <= 5'd0;
      busy <= 1'b0;
      oled_cs_n <= 1'b1;
      oled_sclk <= 1'b1;
      oled_sdin <= 1'b0;
      oled_dc <= 1'b0;
      oled_res_n <= 1'b1;
      oled_vdd_n <= 1'b1;
      oled_vbat_n <= 1'b1;
      byte_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      {s1, s2, s3} <= {sclk_src, s1, s2};
      cnt <= state_nxt != state ? '0 : cnt + CNT_W'(tick);
      oled_vdd_n <= 1'b0;
      oled_res_n <= state_nxt != RES_LOW;
      oled_vbat_n <= !(state_nxt inside {WAIT_VBAT, INIT_B, IDLE, USER_TX});
      byte_ready <= state_nxt == IDLE;
      init_done <= state_nxt inside {IDLE, USER_TX};
      if (load) begin
        oled_cs_n <= 1'b0;
        oled_dc <= ld_dc;
        shreg <= ld_byte;
        bcnt <= 5'd0;
        busy <= 1'b1;
        idx <= idx + 4'd1;
      end else if (busy && tick) begin
        bcnt <= bcnt + 5'd1;
        if (bcnt == 5'd16) begin
          oled_cs_n <= 1'b1;
          busy <= 1'b0;
        end else if (!bcnt[0]) begin
          oled_sclk <= 1'b0;
          oled_sdin <= shreg[7];
        end else begin
          oled_sclk <= 1'b1;
          shreg <= {shreg[6:0], 1'b0};
        end
      end
    end
endmodule

// File: tb/tb_oled_spi_sequencer.sv
// tb_oled_spi_sequencer: randomized self-checking bench with a tick-counting SPI decoder as reference
module tb_oled_spi_sequencer;
  localparam int VDD = 1;
  localparam int RES = 1;
  localparam int VBAT = 10;
  localparam int BT = 17;
  localparam logic [8:0] RST_VEC = 9'b110011100;
  localparam logic [7:0] INIT_SEQ [11] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF, 8'hA4};
  logic clk_in = 1'b0;
  logic reset = 1'b1;
  logic sclk_src = 1'b0;
  logic byte_valid = 1'b0;
  logic byte_is_data = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic byte_ready, init_done, oled_cs_n, oled_sclk, oled_sdin, oled_dc, oled_res_n, oled_vdd_n, oled_vbat_n;
  logic [8:0] outs;
  int n_checks = 0;
  int n_pass = 0;
  int ntick = 0;
  int tog_req = 0;
  int tog_ack = 0;
  bit run = 1'b0;
  int base = 0;
  int t_res_fall = 0;
  int t_res_rise = 0;
  int t_vbat = 0;
  int t_done = 0;
  logic br_at_done = 1'b0;
  int sclk_err = 0;
  logic [8:0] rx [$];

  assign outs = {oled_cs_n, oled_sclk, oled_sdin, oled_dc, oled_res_n, oled_vdd_n, oled_vbat_n, byte_ready, init_done};

  oled_spi_sequencer #(.VDD_TICKS(VDD), .RES_TICKS(RES), .VBAT_TICKS(VBAT), .CNT_W(8)) dut (
    .clk_in(clk_in), .reset(reset), .sclk_src(sclk_src),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
    .byte_ready(byte_ready), .init_done(init_done),
    .oled_cs_n(oled_cs_n), .oled_sclk(oled_sclk), .oled_sdin(oled_sdin), .oled_dc(oled_dc),
    .oled_res_n(oled_res_n), .oled_vdd_n(oled_vdd_n), .oled_vbat_n(oled_vbat_n)
  );

  always #5 clk_in = ~clk_in;

  // Divided clock source: toggles every 20 cycles when running, or once on request.
  // ntick advances on the cycle the resulting tick is live, i.e. just before the edge it acts on.
  initial begin
    int div;
    logic [1:0] tp;
    div = 0;
    tp = 2'b00;
    forever begin
      @(negedge clk_in);
      if (tp[1]) ntick++;
      tp = {tp[0], 1'b0};
      div = run ? div + 1 : 0;
      if (div >= 20 || tog_req != tog_ack) begin
        div = 0;
        sclk_src = ~sclk_src;
        tp[0] = 1'b1;
        if (tog_req != tog_ack) tog_ack++;
      end
    end
  end

  // Pin monitor: event timestamps in ticks and an SPI byte decoder sampling sdin on sclk rise.
  initial begin
    logic pr_res, pr_vbat, pr_done, pr_sclk, pr_cs;
    logic [7:0] sh;
    int bitn;
    pr_res = 1'b1; pr_vbat = 1'b1; pr_done = 1'b0; pr_sclk = 1'b1; pr_cs = 1'b1;
    sh = 8'h00;
    bitn = 0;
    forever begin
      @(negedge clk_in); #1;
      if (pr_res && !oled_res_n) t_res_fall = ntick;
      if (!pr_res && oled_res_n) t_res_rise = ntick;
      if (pr_vbat && !oled_vbat_n) t_vbat = ntick;
      if (!pr_done && init_done) begin
        t_done = ntick;
        br_at_done = byte_ready;
      end
      if (oled_cs_n && !oled_sclk) sclk_err++;
      if (pr_cs && !oled_cs_n) bitn = 0;
      if (!oled_cs_n && !pr_sclk && oled_sclk) begin
        sh = {sh[6:0], oled_sdin};
        bitn++;
        if (bitn == 8) begin
          rx.push_back({oled_dc, sh});
          bitn = 0;
        end
      end
      pr_res = oled_res_n; pr_vbat = oled_vbat_n; pr_done = init_done; pr_sclk = oled_sclk; pr_cs = oled_cs_n;
    end
  end

  function automatic logic [8:0] rx_at(input int i);
    return i < rx.size() ? rx[i] : 9'bx;
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk_in); #2;
    end
  endtask

  task automatic wait_ready(input int limit);
    for (int i = 0; i < limit && !byte_ready; i++) cyc();
  endtask

  task automatic send(input logic [7:0] d, input logic dc, output int t_acc);
    wait_ready(2000);
    byte_valid = 1'b1;
    byte_data = d;
    byte_is_data = dc;
    t_acc = ntick;
    cyc();
    byte_valid = 1'b0;
    byte_data = ~d;
    byte_is_data = ~dc;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(3);
    n_checks++;
    if (outs !== RST_VEC) $display("FAIL reset_values: got %b want %b", outs, RST_VEC); else n_pass++;
  endtask

  task automatic test_init(input bit stall);
    int rx0, diff;
    bit early_ready;
    logic [8:0] snap;
    run = 1'b0;
    reset = 1'b1;
    cyc(4);
    if (sclk_src) tog_req++;
    cyc(4);
    base = ntick;
    rx0 = rx.size();
    reset = 1'b0;
    #1;
    n_checks++;
    if (oled_vdd_n !== 1'b1) $display("FAIL vdd_before_edge: got %b want 1", oled_vdd_n); else n_pass++;
    cyc();
    n_checks++;
    if (oled_vdd_n !== 1'b0) $display("FAIL vdd_after_release: got %b want 0", oled_vdd_n); else n_pass++;
    run = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'($urandom);
    byte_is_data = 1'b1;
    early_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (byte_ready !== 1'b0) early_ready = 1'b1;
    end
    byte_valid = 1'b0;
    n_checks++;
    if (early_ready) $display("FAIL ready_before_init: got 1 want 0"); else n_pass++;
    if (stall) begin
      for (int i = 0; i < 2000 && ntick - base < 40; i++) cyc();
      run = 1'b0;
      cyc(5);
      snap = outs;
      diff = 0;
      for (int i = 0; i < 10000; i++) begin
        cyc();
        if (outs !== snap) diff++;
      end
      n_checks++;
      if (diff != 0) $display("FAIL stall_hold: got %0d changed cycles want 0", diff); else n_pass++;
      run = 1'b1;
    end
    for (int i = 0; i < 6000 && !init_done; i++) cyc();
    n_checks++;
    if (init_done !== 1'b1) $display("FAIL init_done_timeout: got %b want 1", init_done); else n_pass++;
    n_checks++;
    if (t_res_fall - base != VDD) $display("FAIL res_fall_tick: got %0d want %0d", t_res_fall - base, VDD); else n_pass++;
    n_checks++;
    if (t_res_rise - t_res_fall != RES) $display("FAIL res_low_ticks: got %0d want %0d", t_res_rise - t_res_fall, RES); else n_pass++;
    n_checks++;
    if (t_vbat - base != VDD + 2 * RES + 5 * BT) $display("FAIL vbat_tick: got %0d want %0d", t_vbat - base, VDD + 2 * RES + 5 * BT); else n_pass++;
    n_checks++;
    if (t_done - base != VDD + 2 * RES + 11 * BT + VBAT) $display("FAIL done_tick: got %0d want %0d", t_done - base, VDD + 2 * RES + 11 * BT + VBAT); else n_pass++;
    n_checks++;
    if (br_at_done !== 1'b1) $display("FAIL ready_with_done: got %b want 1", br_at_done); else n_pass++;
    n_checks++;
    if (rx.size() - rx0 != 11) $display("FAIL init_byte_count: got %0d want 11", rx.size() - rx0); else n_pass++;
    for (int k = 0; k < 11; k++) begin
      n_checks++;
      if (rx_at(rx0 + k) !== {1'b0, INIT_SEQ[k]}) $display("FAIL init_byte_%0d: got %h want %h", k, rx_at(rx0 + k), {1'b0, INIT_SEQ[k]}); else n_pass++;
    end
    n_checks++;
    if (sclk_err != 0) $display("FAIL sclk_idle_high: got %0d low cycles want 0", sclk_err); else n_pass++;
  endtask

  task automatic test_user_byte;
    int t0, rx0;
    rx0 = rx.size();
    send(8'hA5, 1'b1, t0);
    n_checks++;
    if (byte_ready !== 1'b0) $display("FAIL user_ready_drop: got %b want 0", byte_ready); else n_pass++;
    n_checks++;
    if (oled_dc !== 1'b1) $display("FAIL user_dc: got %b want 1", oled_dc); else n_pass++;
    wait_ready(1000);
    n_checks++;
    if (ntick - t0 != BT) $display("FAIL user_ticks: got %0d want %0d", ntick - t0, BT); else n_pass++;
    n_checks++;
    if (rx_at(rx0) !== 9'h1A5 || rx.size() != rx0 + 1) $display("FAIL user_byte: got %h want 1a5", rx_at(rx0)); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int t0, t1, rx0;
    rx0 = rx.size();
    wait_ready(2000);
    byte_valid = 1'b1;
    byte_data = 8'h3C;
    byte_is_data = 1'b0;
    t0 = ntick;
    cyc();
    byte_data = 8'h7E;
    byte_is_data = 1'b1;
    n_checks++;
    if (byte_ready !== 1'b0) $display("FAIL b2b_ready_drop: got %b want 0", byte_ready); else n_pass++;
    wait_ready(1000);
    t1 = ntick;
    n_checks++;
    if (t1 - t0 != BT) $display("FAIL b2b_first_ticks: got %0d want %0d", t1 - t0, BT); else n_pass++;
    cyc();
    byte_valid = 1'b0;
    n_checks++;
    if (byte_ready !== 1'b0) $display("FAIL b2b_second_accept: got %b want 0", byte_ready); else n_pass++;
    wait_ready(1000);
    n_checks++;
    if (ntick - t1 != BT) $display("FAIL b2b_second_ticks: got %0d want %0d", ntick - t1, BT); else n_pass++;
    n_checks++;
    if (rx.size() - rx0 != 2) $display("FAIL b2b_count: got %0d want 2", rx.size() - rx0); else n_pass++;
    n_checks++;
    if (rx_at(rx0) !== 9'h03C) $display("FAIL b2b_first: got %h want 03c", rx_at(rx0)); else n_pass++;
    n_checks++;
    if (rx_at(rx0 + 1) !== 9'h17E) $display("FAIL b2b_second: got %h want 17e", rx_at(rx0 + 1)); else n_pass++;
  endtask

  task automatic test_random;
    int t0, rx0;
    logic [8:0] exp [$];
    logic [7:0] d;
    logic dc, last_dc;
    rx0 = rx.size();
    last_dc = oled_dc;
    for (int k = 0; k < 6; k++) begin
      wait_ready(2000);
      cyc($urandom_range(0, 30));
      n_checks++;
      if (oled_dc !== last_dc) $display("FAIL rand_dc_hold_%0d: got %b want %b", k, oled_dc, last_dc); else n_pass++;
      d = 8'($urandom);
      dc = 1'($urandom);
      exp.push_back({dc, d});
      send(d, dc, t0);
      wait_ready(1000);
      n_checks++;
      if (ntick - t0 != BT) $display("FAIL rand_ticks_%0d: got %0d want %0d", k, ntick - t0, BT); else n_pass++;
      last_dc = dc;
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (rx_at(rx0 + k) !== exp[k]) $display("FAIL rand_byte_%0d: got %h want %h", k, rx_at(rx0 + k), exp[k]); else n_pass++;
    end
  endtask

  // The request lands a tick exactly on the accept edge; that tick must not count toward the byte.
  task automatic test_accept_tick;
    int t0, rx0;
    logic [7:0] d;
    rx0 = rx.size();
    wait_ready(2000);
    run = 1'b0;
    cyc(5);
    tog_req++;
    cyc(3);
    d = 8'($urandom);
    byte_valid = 1'b1;
    byte_data = d;
    byte_is_data = 1'b0;
    t0 = ntick;
    cyc();
    byte_valid = 1'b0;
    run = 1'b1;
    wait_ready(1000);
    n_checks++;
    if (ntick - t0 != BT) $display("FAIL accept_tick_ticks: got %0d want %0d", ntick - t0, BT); else n_pass++;
    n_checks++;
    if (rx_at(rx0) !== {1'b0, d}) $display("FAIL accept_tick_byte: got %h want %h", rx_at(rx0), {1'b0, d}); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int t0;
    send(8'($urandom), 1'b1, t0);
    for (int i = 0; i < 1000 && ntick - t0 < 8; i++) cyc();
    reset = 1'b1;
    #1;
    n_checks++;
    if (outs !== RST_VEC) $display("FAIL async_reset_values: got %b want %b", outs, RST_VEC); else n_pass++;
    test_init(1'b1);
  endtask

  initial begin
    test_reset();
    test_init(1'b0);
    test_user_byte();
    test_back_to_back();
    test_random();
    test_accept_tick();
    test_reset_mid();
    test_user_byte();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
